// File: rtl/alt_ddrx_lookahead_cache_if.sv
// Bundle of the fetch/status signals that connect the lookahead cache to
// the bank/timer tracker (inputs) and the command-selection FSM (outputs).
interface alt_ddrx_lookahead_cache_if #(
    parameter int MEM_IF_CS_WIDTH      = 4,
    parameter int CTL_LOOK_AHEAD_DEPTH = 4,
    parameter int CTL_CMD_QUEUE_DEPTH  = 8,
    parameter int CNT_W                = 2
);
    localparam int D    = CTL_LOOK_AHEAD_DEPTH;
    localparam int SH_W = $clog2(CTL_LOOK_AHEAD_DEPTH + 2);

    logic [CNT_W-1:0]             fetch_count;
    logic                         ecc_fetch_error_addr;
    logic                         flush;
    logic [CTL_CMD_QUEUE_DEPTH:0] cmd_is_valid;

    logic [MEM_IF_CS_WIDTH-1:0] in_cs_all_banks_closed;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_can_precharge_all;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_can_refresh;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_can_self_refresh;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_can_power_down;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_can_exit_power_saving_mode;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_zq_cal_req;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_power_down_req;
    logic [MEM_IF_CS_WIDTH-1:0] in_cs_refresh_req;

    logic [D:0] in_cmd_bank_is_open;
    logic [D:0] in_cmd_row_is_open;
    logic [D:0] in_cmd_can_write;
    logic [D:0] in_cmd_can_read;
    logic [D:0] in_cmd_can_activate;
    logic [D:0] in_cmd_can_precharge;

    logic [MEM_IF_CS_WIDTH-1:0] out_cs_all_banks_closed;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_can_precharge_all;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_can_refresh;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_can_self_refresh;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_can_power_down;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_can_exit_power_saving_mode;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_zq_cal_req;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_power_down_req;
    logic [MEM_IF_CS_WIDTH-1:0] out_cs_refresh_req;

    logic [D:0]      out_cmd_bank_is_open;
    logic [D:0]      out_cmd_row_is_open;
    logic [D:0]      out_cmd_can_write;
    logic [D:0]      out_cmd_can_read;
    logic [D:0]      out_cmd_can_activate;
    logic [D:0]      out_cmd_can_precharge;
    logic [D:0]      out_cmd_info_valid;
    logic [SH_W-1:0] out_status_shift;

    modport master (
        output fetch_count, ecc_fetch_error_addr, flush, cmd_is_valid,
        output in_cs_all_banks_closed, in_cs_can_precharge_all, in_cs_can_refresh,
        output in_cs_can_self_refresh, in_cs_can_power_down, in_cs_can_exit_power_saving_mode,
        output in_cs_zq_cal_req, in_cs_power_down_req, in_cs_refresh_req,
        output in_cmd_bank_is_open, in_cmd_row_is_open, in_cmd_can_write,
        output in_cmd_can_read, in_cmd_can_activate, in_cmd_can_precharge,
        input  out_cs_all_banks_closed, out_cs_can_precharge_all, out_cs_can_refresh,
        input  out_cs_can_self_refresh, out_cs_can_power_down, out_cs_can_exit_power_saving_mode,
        input  out_cs_zq_cal_req, out_cs_power_down_req, out_cs_refresh_req,
        input  out_cmd_bank_is_open, out_cmd_row_is_open, out_cmd_can_write,
        input  out_cmd_can_read, out_cmd_can_activate, out_cmd_can_precharge,
        input  out_cmd_info_valid, out_status_shift
    );

    modport slave (
        input  fetch_count, ecc_fetch_error_addr, flush, cmd_is_valid,
        input  in_cs_all_banks_closed, in_cs_can_precharge_all, in_cs_can_refresh,
        input  in_cs_can_self_refresh, in_cs_can_power_down, in_cs_can_exit_power_saving_mode,
        input  in_cs_zq_cal_req, in_cs_power_down_req, in_cs_refresh_req,
        input  in_cmd_bank_is_open, in_cmd_row_is_open, in_cmd_can_write,
        input  in_cmd_can_read, in_cmd_can_activate, in_cmd_can_precharge,
        output out_cs_all_banks_closed, out_cs_can_precharge_all, out_cs_can_refresh,
        output out_cs_can_self_refresh, out_cs_can_power_down, out_cs_can_exit_power_saving_mode,
        output out_cs_zq_cal_req, out_cs_power_down_req, out_cs_refresh_req,
        output out_cmd_bank_is_open, out_cmd_row_is_open, out_cmd_can_write,
        output out_cmd_can_read, out_cmd_can_activate, out_cmd_can_precharge,
        output out_cmd_info_valid, out_status_shift
    );
endinterface

// File: rtl/alt_ddrx_lookahead_cache.sv
// Lookahead command-status cache: realigns tracker status vectors to the
// post-fetch queue order (including tracker lag) and generates the
// current-command info-valid with post-fetch / post-ECC deassert windows.
module alt_ddrx_lookahead_cache #(
    parameter int MEM_IF_CS_WIDTH      = 4,
    parameter int CTL_LOOK_AHEAD_DEPTH = 4,
    parameter int CTL_CMD_QUEUE_DEPTH  = 8,
    parameter int FETCH_MAX            = 2,
    parameter int CNT_W                = 2,
    parameter int STATUS_LATENCY       = 0,
    parameter int ROW_LATENCY          = 1,
    parameter int FETCH_GAP            = 1,
    parameter int ECC_GAP              = 1
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_reset_n,
    alt_ddrx_lookahead_cache_if.slave    bus
);
    localparam int D       = CTL_LOOK_AHEAD_DEPTH;
    localparam int SH_W    = $clog2(D + 2);
    localparam int HIST_D  = (STATUS_LATENCY > ROW_LATENCY) ? STATUS_LATENCY : ROW_LATENCY;
    localparam int HD      = (HIST_D > 0) ? HIST_D : 1;
    localparam int MAX_GAP = (FETCH_GAP > ECC_GAP) ? FETCH_GAP : ECC_GAP;
    localparam int HOLD_W  = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
    localparam int unsigned SAT = D + 1;

    localparam logic [CNT_W-1:0]  FMAX_C = CNT_W'(FETCH_MAX);
    localparam logic [HOLD_W-1:0] FG_M1  = HOLD_W'(FETCH_GAP - 1);
    localparam logic [HOLD_W-1:0] EG_M1  = HOLD_W'(ECC_GAP - 1);
    localparam logic [HOLD_W-1:0] MG_M1  = HOLD_W'(MAX_GAP - 1);

    // Total queue movement seen by a tracker output that lags by 'taps'
    // cycles: this cycle's fetch plus the last 'taps' fetches, capped at D+1
    // (everything shifted out).
    function automatic logic [SH_W-1:0] sat_shift(
        input logic [CNT_W-1:0]         now,
        input logic [HD-1:0][CNT_W-1:0] hist,
        input int unsigned              taps
    );
        int unsigned acc;
        acc = 32'(now);
        for (int unsigned k = 0; k < HD; k++) begin
            if (k < taps) acc = acc + 32'(hist[k]);
        end
        if (acc > SAT) acc = SAT;
        return SH_W'(acc);
    endfunction

    logic [CNT_W-1:0]         fc_sat;
    logic                     fetch_ev;
    logic                     any_ev;
    logic [HD-1:0][CNT_W-1:0] hist_q, hist_d, hist_view;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic                     pending_q, pending_d;
    logic                     valid_r_q, valid_r_d;
    logic                     valid0;
    logic [SH_W-1:0]          shift_s, shift_r;
    logic [CTL_CMD_QUEUE_DEPTH:0] cmd_valid_sh;

    assign fc_sat   = (bus.fetch_count > FMAX_C) ? FMAX_C : bus.fetch_count;
    assign fetch_ev = (bus.fetch_count != '0);
    assign any_ev   = fetch_ev | bus.ecc_fetch_error_addr;

    // A flush cycle realigns with its own fetch only; history is discarded.
    assign hist_view = bus.flush ? '0 : hist_q;
    assign shift_s   = sat_shift(fc_sat, hist_view, STATUS_LATENCY);
    assign shift_r   = sat_shift(fc_sat, hist_view, ROW_LATENCY);

    // Fetch history shift register (newest at index 0), cleared by flush.
    always_comb begin
        hist_d    = '0;
        hist_d[0] = fc_sat;
        for (int k = 1; k < HD; k++) hist_d[k] = hist_q[k-1];
        if (HIST_D == 0 || bus.flush) hist_d = '0;
    end

    // Current-command valid: low on events and while a gap is running.
    always_comb begin
        valid0 = valid_r_q;
        if (bus.flush)              valid0 = 1'b0;
        else if (any_ev)            valid0 = 1'b0;
        else if (hold_cnt_q != '0)  valid0 = 1'b0;
        else if (pending_q)         valid0 = 1'b1;
    end

    // Gap counter / pending / registered valid next-state.
    always_comb begin
        logic [HOLD_W-1:0] gap_m1;
        logic [HOLD_W-1:0] hold_dec;
        hold_cnt_d = hold_cnt_q;
        pending_d  = pending_q;
        valid_r_d  = valid0;
        gap_m1     = EG_M1;
        hold_dec   = (hold_cnt_q != '0) ? hold_cnt_q - HOLD_W'(1) : '0;
        if (fetch_ev && bus.ecc_fetch_error_addr) gap_m1 = MG_M1;
        else if (fetch_ev)                        gap_m1 = FG_M1;
        if (bus.flush) begin
            hold_cnt_d = '0;
            pending_d  = 1'b0;
            valid_r_d  = 1'b0;
        end else if (any_ev) begin
            // An overlapping event never shortens a window already running.
            hold_cnt_d = (hold_dec > gap_m1) ? hold_dec : gap_m1;
            pending_d  = 1'b1;
        end else begin
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            if (valid0)           pending_d  = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            hist_q     <= '0;
            hold_cnt_q <= '0;
            pending_q  <= 1'b0;
            valid_r_q  <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            hold_cnt_q <= hold_cnt_d;
            pending_q  <= pending_d;
            valid_r_q  <= valid_r_d;
        end
    end

    // Realigned lookahead status: entry i takes the tracker entry i+S.
    assign bus.out_cmd_bank_is_open  = bus.in_cmd_bank_is_open  >> shift_s;
    assign bus.out_cmd_row_is_open   = bus.in_cmd_row_is_open   >> shift_r;
    assign bus.out_cmd_can_write     = bus.in_cmd_can_write     >> shift_s;
    assign bus.out_cmd_can_read      = bus.in_cmd_can_read      >> shift_s;
    assign bus.out_cmd_can_activate  = bus.in_cmd_can_activate  >> shift_s;
    assign bus.out_cmd_can_precharge = bus.in_cmd_can_precharge >> shift_s;
    assign bus.out_status_shift      = shift_s;

    assign cmd_valid_sh = bus.cmd_is_valid >> shift_s;

    // Info-valid: lookahead entries from the shifted queue valids; entry 0
    // is additionally gated by the current-command valid.
    always_comb begin
        bus.out_cmd_info_valid = bus.cmd_is_valid[D:0] >> shift_s;
        if (shift_s == '0) bus.out_cmd_info_valid[0] = valid0;
        else               bus.out_cmd_info_valid[0] = cmd_valid_sh[0] & valid0;
    end

    assign bus.out_cs_all_banks_closed           = bus.in_cs_all_banks_closed;
    assign bus.out_cs_can_precharge_all          = bus.in_cs_can_precharge_all;
    assign bus.out_cs_can_refresh                = bus.in_cs_can_refresh;
    assign bus.out_cs_can_self_refresh           = bus.in_cs_can_self_refresh;
    assign bus.out_cs_can_power_down             = bus.in_cs_can_power_down;
    assign bus.out_cs_can_exit_power_saving_mode = bus.in_cs_can_exit_power_saving_mode;
    assign bus.out_cs_zq_cal_req                 = bus.in_cs_zq_cal_req;
    assign bus.out_cs_power_down_req             = bus.in_cs_power_down_req;
    assign bus.out_cs_refresh_req                = bus.in_cs_refresh_req;
endmodule

// File: tb/tb_alt_ddrx_lookahead_cache.sv
// Bench for the lookahead cache: two configurations driven by one stimulus
// stream, checked against a cycle-indexed behavioural model.
module tb_alt_ddrx_lookahead_cache;
    localparam int D = 4, Q = 8, CS = 4, CW = 2, FM = 2;

    logic ctl_clk = 1'b0;
    logic ctl_reset_n = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    logic [CW-1:0] fc = '0;
    logic ecc = 1'b0, fl = 1'b0;
    logic [Q:0] cv = '0;
    logic [D:0] in_bank = '0, in_row = '0, in_wr = '0, in_rd = '0, in_act = '0, in_pre = '0;
    logic [8:0][CS-1:0] cs_in = '0;

    alt_ddrx_lookahead_cache_if #(.MEM_IF_CS_WIDTH(CS), .CTL_LOOK_AHEAD_DEPTH(D),
        .CTL_CMD_QUEUE_DEPTH(Q), .CNT_W(CW)) if_a ();
    alt_ddrx_lookahead_cache_if #(.MEM_IF_CS_WIDTH(CS), .CTL_LOOK_AHEAD_DEPTH(D),
        .CTL_CMD_QUEUE_DEPTH(Q), .CNT_W(CW)) if_b ();

    alt_ddrx_lookahead_cache #(.MEM_IF_CS_WIDTH(CS), .CTL_LOOK_AHEAD_DEPTH(D),
        .CTL_CMD_QUEUE_DEPTH(Q), .FETCH_MAX(FM), .CNT_W(CW), .STATUS_LATENCY(0),
        .ROW_LATENCY(1), .FETCH_GAP(1), .ECC_GAP(2))
        dut_a (.ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n), .bus(if_a));
    alt_ddrx_lookahead_cache #(.MEM_IF_CS_WIDTH(CS), .CTL_LOOK_AHEAD_DEPTH(D),
        .CTL_CMD_QUEUE_DEPTH(Q), .FETCH_MAX(FM), .CNT_W(CW), .STATUS_LATENCY(1),
        .ROW_LATENCY(2), .FETCH_GAP(3), .ECC_GAP(1))
        dut_b (.ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n), .bus(if_b));

    int sl[2] = '{0, 1};
    int rl[2] = '{1, 2};
    int fg[2] = '{1, 3};
    int eg[2] = '{2, 1};

    assign if_a.fetch_count = fc;  assign if_b.fetch_count = fc;
    assign if_a.ecc_fetch_error_addr = ecc;  assign if_b.ecc_fetch_error_addr = ecc;
    assign if_a.flush = fl;  assign if_b.flush = fl;
    assign if_a.cmd_is_valid = cv;  assign if_b.cmd_is_valid = cv;
    assign if_a.in_cmd_bank_is_open = in_bank;  assign if_b.in_cmd_bank_is_open = in_bank;
    assign if_a.in_cmd_row_is_open = in_row;  assign if_b.in_cmd_row_is_open = in_row;
    assign if_a.in_cmd_can_write = in_wr;  assign if_b.in_cmd_can_write = in_wr;
    assign if_a.in_cmd_can_read = in_rd;  assign if_b.in_cmd_can_read = in_rd;
    assign if_a.in_cmd_can_activate = in_act;  assign if_b.in_cmd_can_activate = in_act;
    assign if_a.in_cmd_can_precharge = in_pre;  assign if_b.in_cmd_can_precharge = in_pre;
    assign {if_a.in_cs_all_banks_closed, if_a.in_cs_can_precharge_all, if_a.in_cs_can_refresh,
            if_a.in_cs_can_self_refresh, if_a.in_cs_can_power_down, if_a.in_cs_can_exit_power_saving_mode,
            if_a.in_cs_zq_cal_req, if_a.in_cs_power_down_req, if_a.in_cs_refresh_req} = cs_in;
    assign {if_b.in_cs_all_banks_closed, if_b.in_cs_can_precharge_all, if_b.in_cs_can_refresh,
            if_b.in_cs_can_self_refresh, if_b.in_cs_can_power_down, if_b.in_cs_can_exit_power_saving_mode,
            if_b.in_cs_zq_cal_req, if_b.in_cs_power_down_req, if_b.in_cs_refresh_req} = cs_in;

    logic [6*(D+1)-1:0] o_cmd [2];
    logic [D:0]         o_iv  [2];
    logic [2:0]         o_sh  [2];
    logic [9*CS-1:0]    o_cs  [2];
    assign o_cmd[0] = {if_a.out_cmd_bank_is_open, if_a.out_cmd_row_is_open, if_a.out_cmd_can_write,
                       if_a.out_cmd_can_read, if_a.out_cmd_can_activate, if_a.out_cmd_can_precharge};
    assign o_cmd[1] = {if_b.out_cmd_bank_is_open, if_b.out_cmd_row_is_open, if_b.out_cmd_can_write,
                       if_b.out_cmd_can_read, if_b.out_cmd_can_activate, if_b.out_cmd_can_precharge};
    assign o_iv[0] = if_a.out_cmd_info_valid;  assign o_iv[1] = if_b.out_cmd_info_valid;
    assign o_sh[0] = if_a.out_status_shift;    assign o_sh[1] = if_b.out_status_shift;
    assign o_cs[0] = {if_a.out_cs_all_banks_closed, if_a.out_cs_can_precharge_all, if_a.out_cs_can_refresh,
                      if_a.out_cs_can_self_refresh, if_a.out_cs_can_power_down, if_a.out_cs_can_exit_power_saving_mode,
                      if_a.out_cs_zq_cal_req, if_a.out_cs_power_down_req, if_a.out_cs_refresh_req};
    assign o_cs[1] = {if_b.out_cs_all_banks_closed, if_b.out_cs_can_precharge_all, if_b.out_cs_can_refresh,
                      if_b.out_cs_can_self_refresh, if_b.out_cs_can_power_down, if_b.out_cs_can_exit_power_saving_mode,
                      if_b.out_cs_zq_cal_req, if_b.out_cs_power_down_req, if_b.out_cs_refresh_req};

    int checks = 0;
    int errors = 0;

    // Reference model: list of past (saturated) fetch counts, an "armed"
    // flag (a fetch/ECC happened since the last clear) and, per
    // configuration, the last cycle index that must still read invalid.
    int fc_hist[$];
    bit armed = 1'b0;
    int low_until[2] = '{-1, -1};
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int fcs();
        return (int'(fc) > FM) ? FM : int'(fc);
    endfunction

    function automatic int exp_shift(input int lat);
        int acc = fcs();
        if (!fl) begin
            for (int j = 0; j < lat; j++)
                if (fc_hist.size() > j) acc += fc_hist[fc_hist.size()-1-j];
        end
        return (acc > D + 1) ? D + 1 : acc;
    endfunction

    function automatic logic [D:0] shv(input logic [D:0] v, input int s);
        logic [D:0] r = '0;
        for (int i = 0; i <= D; i++) if (i + s <= D) r[i] = v[i+s];
        return r;
    endfunction

    function automatic bit exp_v0(input int k);
        if (!ctl_reset_n || fl || fc != '0 || ecc) return 1'b0;
        if (cyc <= low_until[k]) return 1'b0;
        return armed;
    endfunction

    function automatic logic [D:0] exp_iv(input int s, input bit v0);
        logic [D:0] r = '0;
        for (int i = 1; i <= D; i++) if (i + s <= D) r[i] = cv[i+s];
        if (s == 0)      r[0] = v0;
        else if (s <= Q) r[0] = cv[s] & v0;
        return r;
    endfunction

    task automatic model_clear();
        fc_hist.delete();
        armed = 1'b0;
        low_until[0] = -1;
        low_until[1] = -1;
    endtask

    task automatic model_step();
        if (!ctl_reset_n || fl) begin
            model_clear();
        end else begin
            fc_hist.push_back(fcs());
            if (fc_hist.size() > 8) void'(fc_hist.pop_front());
            if (fc != '0 || ecc) begin
                armed = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    int g;
                    if (fc != '0 && ecc) g = (fg[k] > eg[k]) ? fg[k] : eg[k];
                    else if (fc != '0)   g = fg[k];
                    else                 g = eg[k];
                    if (cyc + g - 1 > low_until[k]) low_until[k] = cyc + g - 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int s, r;
            bit v0;
            s  = exp_shift(sl[k]);
            r  = exp_shift(rl[k]);
            v0 = exp_v0(k);
            chk($sformatf("cmd%0d@%0d", k, cyc), 64'(o_cmd[k]),
                64'({shv(in_bank, s), shv(in_row, r), shv(in_wr, s), shv(in_rd, s), shv(in_act, s), shv(in_pre, s)}));
            chk($sformatf("info_valid%0d@%0d", k, cyc), 64'(o_iv[k]), 64'(exp_iv(s, v0)));
            chk($sformatf("shift%0d@%0d", k, cyc), 64'(o_sh[k]), 64'(s));
            chk($sformatf("cs%0d@%0d", k, cyc), 64'(o_cs[k]), 64'(cs_in));
        end
    endtask

    task automatic step(input int f, input bit e, input bit x);
        fc = CW'(f); ecc = e; fl = x;
        @(negedge ctl_clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge ctl_clk);
        model_step();
        #1;
    endtask

    initial begin
        cv = '1; in_bank = 5'b11111; in_row = 5'b11111; in_rd = 5'b10110;
        in_wr = 5'b01101; in_act = 5'b10011; in_pre = 5'b00110;
        cs_in = 36'h9A5C3_E71B;
        // reset
        step(0, 0, 0);
        chk("rst_can_read", 64'(if_a.out_cmd_can_read), 64'(5'b10110));
        chk("rst_valid0", 64'(if_a.out_cmd_info_valid[0]), 64'd0);
        advance();
        ctl_reset_n = 1'b1;
        step(0, 0, 0); advance();
        // single fetch, default gap
        step(1, 0, 0);
        chk("f1_can_read", 64'(if_a.out_cmd_can_read), 64'(5'b01011));
        chk("f1_v0_t0", 64'(if_a.out_cmd_info_valid[0]), 64'd0);
        advance();
        step(0, 0, 0);
        chk("f1_can_read_t1", 64'(if_a.out_cmd_can_read), 64'(5'b10110));
        chk("f1_row_t1", 64'(if_a.out_cmd_row_is_open), 64'(5'b01111));
        chk("f1_v0_t1", 64'(if_a.out_cmd_info_valid[0]), 64'd1);
        advance();
        step(0, 0, 0);
        chk("f1_v0_t2", 64'(if_a.out_cmd_info_valid[0]), 64'd1);
        advance();
        // double fetches
        step(2, 0, 0);
        chk("f2_bank", 64'(if_a.out_cmd_bank_is_open), 64'(5'b00111));
        advance();
        step(2, 0, 0);
        chk("f2f2_row", 64'(if_a.out_cmd_row_is_open), 64'(5'b00001));
        advance();
        step(0, 0, 1); advance();
        step(0, 0, 0); advance(); step(0, 0, 0); advance();
        // FETCH_GAP=3 window on dut_b
        step(1, 0, 0); chk("g3_t0", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("g3_t1", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("g3_t2", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("g3_t3", 64'(if_b.out_cmd_info_valid[0]), 64'd1); advance();
        // overlapping fetch extends the window
        step(1, 0, 0); advance();
        step(1, 0, 0); advance();
        step(0, 0, 0); chk("g3x_t2", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("g3x_t3", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("g3x_t4", 64'(if_b.out_cmd_info_valid[0]), 64'd1); advance();
        // ECC + fetch on dut_a (ECC_GAP=2)
        step(1, 1, 0); chk("ecc_t0", 64'(if_a.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("ecc_t1", 64'(if_a.out_cmd_info_valid[0]), 64'd0); advance();
        step(0, 0, 0); chk("ecc_t2", 64'(if_a.out_cmd_info_valid[0]), 64'd1); advance();
        // flush in the middle of a dut_b gap
        step(1, 0, 0); advance();
        step(0, 0, 1); chk("fl_t1", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0); chk("fl_hold", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        end
        step(1, 0, 0); advance(); step(0, 0, 0); advance(); step(0, 0, 0); advance();
        step(0, 0, 0); chk("fl_resume", 64'(if_b.out_cmd_info_valid[0]), 64'd1); advance();
        // fetch_count saturation
        step(3, 0, 0); chk("sat_shift", 64'(if_a.out_status_shift), 64'd2); advance();
        step(0, 0, 0); advance(); step(0, 0, 0); advance(); step(0, 0, 0); advance();
        // asynchronous reset in the middle of a dut_b gap
        step(1, 0, 0); advance();
        fc = '0;
        ctl_reset_n = 1'b0;
        model_clear();
        step(0, 0, 0);
        chk("arst_v0", 64'(if_b.out_cmd_info_valid[0]), 64'd0);
        chk("arst_shift", 64'(if_b.out_status_shift), 64'd0);
        chk("arst_row", 64'(if_b.out_cmd_row_is_open), 64'(in_row));
        advance();
        ctl_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0); chk("arst_hold", 64'(if_b.out_cmd_info_valid[0]), 64'd0); advance();
        end
        step(1, 0, 0); advance(); step(0, 0, 0); advance(); step(0, 0, 0); advance();
        step(0, 0, 0); chk("arst_resume", 64'(if_b.out_cmd_info_valid[0]), 64'd1); advance();
        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int f;
            cv = Q'($urandom); cv[Q] = 1'($urandom);
            in_bank = 5'($urandom); in_row = 5'($urandom); in_wr = 5'($urandom);
            in_rd = 5'($urandom); in_act = 5'($urandom); in_pre = 5'($urandom);
            cs_in = {4'($urandom), 32'($urandom)};
            f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0;
            if ($urandom_range(0, 199) == 0) begin
                ctl_reset_n = 1'b0;
                model_clear();
                step(f, 1'b0, 1'b0);
                advance();
                ctl_reset_n = 1'b1;
            end else begin
                step(f, ($urandom_range(0, 11) == 0), ($urandom_range(0, 29) == 0));
                advance();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
